// File: rtl/encout_seq_ctrl.sv
// encout_seq_ctrl: command sequencer for the encoder-output phase generator.
// Buffers signed per-period edge counts and issues one ELC event plus OUTCNT load per period.
module encout_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          i_pclk,
  input  logic          i_presetn,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic [15:0]   i_period,
  input  logic          i_cmd_vld,
  output logic          o_cmd_rdy,
  input  logic [15:0]   i_cmd_data,
  input  logic          i_clr_underrun,
  output logic          o_str,
  output logic          o_elcin,
  output logic [15:0]   o_outcnt,
  output logic          o_underrun,
  output logic          o_busy,
  output logic [AW:0]   o_fifo_level
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
  localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [15:0] timer_q, timer_d, period_q, period_d, outcnt_q, outcnt_d;
  logic str_q, str_d, elcin_q, elcin_d, und_q, und_d;
  logic [AW:0] level_q, level_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [15:0] mem_q [DEPTH];
  logic push, pop, flush, slot, last, empty;
  logic [15:0] period_clamped;
  assign empty          = level_q == '0;
  assign o_cmd_rdy      = level_q != full_lvl;
  assign flush          = i_flush && state_q == IDLE;
  assign push           = i_cmd_vld && o_cmd_rdy && !flush;
  assign slot           = state_q == RUN && timer_q == '0;
  assign pop            = slot && i_en && !empty;
  assign last           = timer_q == period_q - 16'd1;
  assign period_clamped = (i_period < 16'd2) ? 16'd2 : i_period;
  // A flush resets both pointers so the FIFO restarts from a clean slot 0.
  always_comb begin
    wr_d    = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
    rd_d    = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
    level_d = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_comb begin
    state_d  = state_q;
    str_d    = str_q;
    timer_d  = '0;
    period_d = period_q;
    outcnt_d = outcnt_q;
    elcin_d  = 1'b0;
    und_d    = i_clr_underrun ? 1'b0 : und_q;
    case (state_q)
      IDLE: if (i_en && !empty) begin
        state_d  = ARM;
        str_d    = 1'b1;
        period_d = period_clamped;
      end
      ARM: if (!i_en) begin
        state_d = IDLE;
        str_d   = 1'b0;
      end else state_d = RUN;
      RUN: begin
        timer_d = last ? '0 : timer_q + 16'd1;
        if (pop) begin
          elcin_d  = 1'b1;
          outcnt_d = mem_q[rd_q];
          period_d = period_clamped;
        end else if (slot) begin
          state_d = IDLE;
          str_d   = 1'b0;
          timer_d = '0;
          und_d   = i_en ? 1'b1 : und_d;
        end else if (!i_en) state_d = DRAIN;
      end
      DRAIN: if (last) begin
        state_d = IDLE;
        str_d   = 1'b0;
      end else timer_d = timer_q + 16'd1;
    endcase
  end
  always_ff @(posedge i_pclk or negedge i_presetn)
    if (!i_presetn) begin
      state_q  <= IDLE;
      str_q    <= 1'b0;
      timer_q  <= '0;
      period_q <= 16'd2;
      outcnt_q <= '0;
      elcin_q  <= 1'b0;
      und_q    <= 1'b0;
      level_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      str_q    <= str_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      outcnt_q <= outcnt_d;
      elcin_q  <= elcin_d;
      und_q    <= und_d;
      level_q  <= level_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  always_ff @(posedge i_pclk)
    if (push) mem_q[wr_q] <= i_cmd_data;
  assign o_str        = str_q;
  assign o_elcin      = elcin_q;
  assign o_outcnt     = outcnt_q;
  assign o_underrun   = und_q;
  assign o_busy       = state_q != IDLE;
  assign o_fifo_level = level_q;
endmodule

// File: tb/tb_encout_seq_ctrl.sv
// tb_encout_seq_ctrl: directed bench for encout_seq_ctrl with an outcnt scoreboard.
module tb_encout_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  logic i_pclk = 1'b0, i_presetn = 1'b0, i_en = 1'b0, i_flush = 1'b0;
  logic i_cmd_vld = 1'b0, i_clr_underrun = 1'b0;
  logic [15:0] i_period = 16'd10, i_cmd_data = '0;
  logic o_cmd_rdy, o_str, o_elcin, o_underrun, o_busy;
  logic [15:0] o_outcnt;
  logic [AW:0] o_fifo_level;
  int checks = 0, failures = 0, seen = 0;
  bit auto_drop = 1'b0;
  logic [15:0] exp_q [$];
  always #5 i_pclk = ~i_pclk;
  encout_seq_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_pclk(i_pclk), .i_presetn(i_presetn), .i_en(i_en), .i_flush(i_flush),
    .i_period(i_period), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_data(i_cmd_data), .i_clr_underrun(i_clr_underrun), .o_str(o_str),
    .o_elcin(o_elcin), .o_outcnt(o_outcnt), .o_underrun(o_underrun),
    .o_busy(o_busy), .o_fifo_level(o_fifo_level)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: the scoreboard learns what the FIFO should accept on this edge.
  task automatic tick();
    bit acc;
    acc = 1'b0;
    if (i_flush && !o_busy) exp_q.delete();
    else if (i_cmd_vld && o_cmd_rdy) begin
      exp_q.push_back(i_cmd_data);
      acc = 1'b1;
    end
    @(posedge i_pclk);
    #1;
    if (acc && auto_drop) i_cmd_vld = 1'b0;
    if (o_elcin) seen++;
  endtask
  task automatic push(input logic [15:0] d);
    i_cmd_vld  = 1'b1;
    i_cmd_data = d;
    tick();
    i_cmd_vld  = 1'b0;
  endtask
  task automatic wait_evt(input string tag, input int exp_gap);
    int n;
    logic [15:0] e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_elcin && n < 40);
    chk({tag, "_gap"}, n, exp_gap);
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_outcnt"}, o_outcnt, e);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_str", o_str, 0);
    chk("rst_elcin", o_elcin, 0);
    chk("rst_outcnt", o_outcnt, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_level", o_fifo_level, 0);
    chk("rst_rdy", o_cmd_rdy, 1);
    i_presetn = 1'b1;
    push(16'h0003);
    push(16'hFFFE);
    push(16'h0005);
    chk("b_level", o_fifo_level, 3);
    chk("b_idle", o_busy, 0);
    i_en = 1'b1;
    tick();
    chk("b_str_k", o_str, 1);
    chk("b_busy_k", o_busy, 1);
    wait_evt("b1", 2);
    wait_evt("b2", 10);
    wait_evt("b3", 10);
    repeat (9) tick();
    chk("b_pre_und", o_underrun, 0);
    chk("b_pre_str", o_str, 1);
    i_clr_underrun = 1'b1;
    tick();
    chk("b_und_set_wins", o_underrun, 1);
    chk("b_und_str", o_str, 0);
    chk("b_und_busy", o_busy, 0);
    chk("b_outcnt_hold", o_outcnt, 16'h0005);
    tick();
    chk("b_und_clr", o_underrun, 0);
    i_clr_underrun = 1'b0;
    i_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_cmd_vld  = 1'b1;
      i_cmd_data = 16'(16'h10 + i);
      tick();
      if (i == 3) begin
        chk("bp_rdy_full", o_cmd_rdy, 0);
        chk("bp_level4", o_fifo_level, 4);
      end
    end
    chk("bp_level6", o_fifo_level, 4);
    i_cmd_data = 16'h0014;
    auto_drop  = 1'b1;
    i_period   = 16'd10;
    i_en       = 1'b1;
    tick();
    wait_evt("p1", 2);
    chk("p1_level", o_fifo_level, 3);
    i_period = 16'd4;
    wait_evt("p2", 10);
    chk("p2_level", o_fifo_level, 3);
    i_period = 16'd1;
    wait_evt("p3", 4);
    i_period = 16'd0;
    wait_evt("p4", 2);
    wait_evt("p5", 2);
    tick();
    chk("p_pre_und", o_underrun, 0);
    tick();
    chk("p_und", o_underrun, 1);
    chk("p_und_busy", o_busy, 0);
    auto_drop      = 1'b0;
    i_clr_underrun = 1'b1;
    i_en           = 1'b0;
    tick();
    i_clr_underrun = 1'b0;
    i_period = 16'd8;
    push(16'h0021);
    push(16'h0022);
    push(16'h0023);
    i_en = 1'b1;
    tick();
    wait_evt("d1", 2);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("d_flush_run_level", o_fifo_level, 2);
    tick();
    i_en = 1'b0;
    seen = 0;
    tick();
    chk("d_drain_busy", o_busy, 1);
    i_en = 1'b1;
    tick();
    tick();
    i_en = 1'b0;
    tick();
    chk("d_drain_str", o_str, 1);
    tick();
    chk("d_stop_str", o_str, 0);
    chk("d_stop_busy", o_busy, 0);
    chk("d_no_pulse", seen, 0);
    chk("d_retained", o_fifo_level, 2);
    i_flush    = 1'b1;
    i_cmd_vld  = 1'b1;
    i_cmd_data = 16'h0099;
    tick();
    i_flush   = 1'b0;
    i_cmd_vld = 1'b0;
    chk("f_idle_level", o_fifo_level, 0);
    chk("f_idle_rdy", o_cmd_rdy, 1);
    i_period = 16'd5;
    push(16'h0031);
    push(16'h0032);
    i_en = 1'b1;
    tick();
    wait_evt("r1", 2);
    chk("r_elcin_pre", o_elcin, 1);
    i_presetn = 1'b0;
    #1;
    chk("r_elcin", o_elcin, 0);
    chk("r_str", o_str, 0);
    chk("r_outcnt", o_outcnt, 0);
    chk("r_level", o_fifo_level, 0);
    chk("r_busy", o_busy, 0);
    chk("r_rdy", o_cmd_rdy, 1);
    exp_q.delete();
    i_en = 1'b0;
    #1;
    i_presetn = 1'b1;
    i_en = 1'b1;
    repeat (5) tick();
    chk("r_no_restart_busy", o_busy, 0);
    chk("r_no_restart_str", o_str, 0);
    i_en = 1'b0;
    push(16'h0041);
    i_en = 1'b1;
    tick();
    wait_evt("r2", 2);
    i_en = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
